// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding and default datapath widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous skid FIFO. Flush beats push; a push and a pop in the
// same cycle are both honoured even when the FIFO is full. The head output
// reads as zero while empty, so it never shows uninitialised storage.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Storage write; data words carry no reset, validity lives in count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses a combinational
// instruction memory, buffers {instr, pc} pairs in a skid FIFO towards
// decode, and handles redirects/flushes and end-of-program halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_DEPTH  = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_END = ADDR_W'(MEM_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              halt_q, halt_d;
    logic              push, pop, flush;
    logic              full, empty;
    logic [CNT_W-1:0]  count, cnt_after;
    logic [ENT_W-1:0]  head;

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({imem_data, fetch_pc_q}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = !empty && (state_q != HALT);
    assign out_instr = head[ADDR_W +: DATA_W];
    assign out_pc    = head[ADDR_W-1:0];
    assign halt      = halt_q;
    assign pop       = out_valid && out_ready;
    assign flush     = redirect_valid;
    // Occupancy once this cycle's handshake has been taken into account.
    assign cnt_after = count - CNT_W'(pop);

    // State, PC and halt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            halt_q     <= halt_d;
        end
    end

    // Next-state, push decision and redirect muxing; redirect overrides all.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        halt_d     = halt_q;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halt_d     = 1'b0;
            state_d    = (redirect_pc < PC_END) ? FETCH : DRAIN;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) state_d = FETCH;
                end
                FETCH: begin
                    if (fetch_pc_q >= PC_END) begin
                        state_d = DRAIN;
                    end else if (enable && (!full || pop)) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        if (fetch_pc_d == PC_END) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_after == '0) begin
                        state_d = HALT;
                        halt_d  = 1'b1;
                    end
                end
                HALT: begin
                    halt_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based
// behavioural model of the fetch/deliver/halt rules.
module tb_fetch_sequencer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 6;
    localparam int FDEP  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int            m_mode;      // 0 waiting for enable, 1 fetching, 2 draining, 3 halted
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_q[$];
    bit            m_halt;
    bit            m_known = 0;
    bit            m_zero  = 0;
    logic [AW-1:0] delivered[$];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    assign imem_data = memfn(imem_addr);

    fetch_sequencer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_DEPTH  (DEPTH),
        .FIFO_DEPTH (FDEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, drive inputs, advance the model.
    task automatic cyc(input bit r, input bit en, input bit rdy, input bit rv,
                       input logic [AW-1:0] rpc);
        bit pop;
        @(negedge clk);
        if (m_known) begin
            check_val("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check_val("halt", 64'(halt), 64'(m_halt));
            check_val("imem_addr", 64'(imem_addr), 64'(m_pc));
            if (m_q.size() > 0) begin
                check_val("out_pc", 64'(out_pc), 64'(m_q[0]));
                check_val("out_instr", 64'(out_instr), 64'(memfn(m_q[0])));
            end else if (m_zero) begin
                check_val("out_pc_rst", 64'(out_pc), 64'(0));
                check_val("out_instr_rst", 64'(out_instr), 64'(0));
            end
            if (out_valid && rdy) delivered.push_back(out_pc);
        end
        reset          = r;
        enable         = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        m_zero = r;
        if (r) begin
            m_known = 1;
            m_mode  = 0;
            m_pc    = '0;
            m_q.delete();
            m_halt  = 0;
        end else if (m_known) begin
            pop = (m_q.size() > 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (rv) begin
                m_q.delete();
                m_pc   = rpc;
                m_halt = 0;
                m_mode = (rpc < DEPTH) ? 1 : 2;
            end else begin
                case (m_mode)
                    0: if (en) m_mode = 1;
                    1: begin
                        if (m_pc >= DEPTH) m_mode = 2;
                        else if (en && m_q.size() < FDEP) begin
                            m_q.push_back(m_pc);
                            m_pc = m_pc + 1;
                            if (m_pc == DEPTH) m_mode = 2;
                        end
                    end
                    2: if (m_q.size() == 0) begin
                        m_mode = 3;
                        m_halt = 1;
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // Straight run: pcs 0..5 in order, then halt.
        cyc(1, 0, 0, 0, 0);
        delivered.delete();
        for (int i = 0; i < 11; i++) cyc(0, 1, 1, 0, 0);
        check_val("straight_count", 64'(delivered.size()), 64'(DEPTH));
        for (int i = 0; i < delivered.size() && i < DEPTH; i++)
            check_val("straight_order", 64'(delivered[i]), 64'(i));
        check_val("straight_halt", 64'(halt), 64'(1));

        // Backpressure: ready low for a while, then release.
        cyc(1, 0, 0, 0, 0);
        delivered.delete();
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
        check_val("bp_addr_stuck", 64'(imem_addr), 64'(2));
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
        check_val("bp_count", 64'(delivered.size()), 64'(DEPTH));
        for (int i = 0; i < delivered.size() && i < DEPTH; i++)
            check_val("bp_order", 64'(delivered[i]), 64'(i));

        // Redirect flush with pcs 3 and 4 buffered.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0);

        // Out-of-range redirect, then redirect back from halt.
        cyc(0, 1, 1, 1, 7);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);

        // Enable pause and resume.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);

        // Mid-run reset with a full FIFO.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, en, rdy, rv;
            logic [AW-1:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 8));
            cyc(r, en, rdy, rv, rpc);
        end
        cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
